// File: rtl/audio_delay_fx.sv
// Delay-line audio effect engine: bypass, echo, reverb and inverse comb over a
// circular history buffer, with valid/ready streaming on both sides.
module audio_delay_fx #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DELAY   = 2048,
  parameter int unsigned ALPHA_Q = 8
) (
  input  logic                      clkFPGA,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic [ALPHA_Q-1:0]        alpha,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   in_sample,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   out_sample,
  output logic                      busy,
  output logic [1:0]                mode_active,
  output logic                      sat_flag
);

  localparam int unsigned AW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int unsigned PW = WIDTH + ALPHA_Q + 2;
  localparam logic [AW-1:0] LAST = AW'(DELAY - 1);
  localparam logic signed [PW-1:0] Y_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] Y_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_IN, S_READ, S_CALC, S_OUT
  } state_e;

  state_e                    state_q, state_d;
  logic [AW-1:0]             ptr_q, ptr_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic [1:0]                mode_q, mode_d;
  logic [ALPHA_Q-1:0]        alpha_q, alpha_d;
  logic signed [WIDTH-1:0]   x_q, x_d;
  logic signed [WIDTH-1:0]   h_q;
  logic                      stop_q, stop_d;
  logic signed [WIDTH-1:0]   out_sample_q, out_sample_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;
  logic                      busy_q, busy_d;
  logic [1:0]                mode_active_q, mode_active_d;
  logic                      sat_q, sat_d;

  logic signed [WIDTH-1:0]   buf_mem [DELAY];
  logic                      mem_we_c;
  logic [AW-1:0]             mem_addr_c;
  logic signed [WIDTH-1:0]   mem_wdata_c;

  logic signed [PW-1:0]      a_ext, b_ext, x_ext, h_ext, ah, y_full;
  logic signed [WIDTH-1:0]   y_sat;
  logic                      clip;

  // History RAM: synchronous read in READ, contents survive reset.
  always_ff @(posedge clkFPGA) begin
    if (mem_we_c && !rst) buf_mem[mem_addr_c] <= mem_wdata_c;
    if (state_q == S_READ) h_q <= buf_mem[ptr_q];
  end

  // Effect arithmetic at full precision, then saturation to WIDTH.
  always_comb begin
    a_ext  = PW'(alpha_q);
    b_ext  = $signed(PW'(1) << ALPHA_Q) - a_ext;
    x_ext  = PW'(x_q);
    h_ext  = PW'(h_q);
    ah     = a_ext * h_ext;
    y_full = x_ext;
    unique case (mode_q)
      2'b01, 2'b10: y_full = (b_ext * x_ext + ah) >>> ALPHA_Q;
      2'b11:        y_full = x_ext - (ah >>> ALPHA_Q);
      default:      y_full = x_ext;
    endcase
    clip  = 1'b0;
    y_sat = WIDTH'(y_full);
    if (y_full > Y_MAX) begin
      clip  = 1'b1;
      y_sat = WIDTH'(Y_MAX);
    end else if (y_full < Y_MIN) begin
      clip  = 1'b1;
      y_sat = WIDTH'(Y_MIN);
    end
  end

  always_ff @(posedge clkFPGA) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      mode_q        <= '0;
      alpha_q       <= '0;
      x_q           <= '0;
      stop_q        <= 1'b0;
      out_sample_q  <= '0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      mode_active_q <= '0;
      sat_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      alpha_q       <= alpha_d;
      x_q           <= x_d;
      stop_q        <= stop_d;
      out_sample_q  <= out_sample_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      mode_active_q <= mode_active_d;
      sat_q         <= sat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    alpha_d      = alpha_q;
    x_d          = x_q;
    stop_d       = stop_q;
    out_sample_d = out_sample_q;
    sat_d        = sat_q;
    mem_we_c     = 1'b0;
    mem_addr_c   = ptr_q;
    mem_wdata_c  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          alpha_d = alpha;
          sat_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mem_we_c   = 1'b1;
        mem_addr_c = cnt_q;
        cnt_d      = cnt_q + AW'(1);
        if (cnt_q == LAST) begin
          ptr_d   = '0;
          state_d = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        if (in_valid && in_ready_q) begin
          x_d     = in_sample;
          stop_d  = stop;
          state_d = S_READ;
        end else if (stop) begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        stop_d  = stop_q | stop;
        state_d = S_CALC;
      end
      S_CALC: begin
        stop_d       = stop_q | stop;
        out_sample_d = y_sat;
        if (clip) sat_d = 1'b1;
        mem_we_c     = 1'b1;
        mem_wdata_c  = (mode_q == 2'b10) ? y_sat : x_q;
        ptr_d        = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
        state_d      = S_OUT;
      end
      S_OUT: begin
        stop_d = stop_q | stop;
        if (out_ready) state_d = (stop_q || stop) ? S_IDLE : S_WAIT_IN;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the upcoming state.
    in_ready_d    = (state_d == S_WAIT_IN);
    out_valid_d   = (state_d == S_OUT);
    busy_d        = (state_d != S_IDLE);
    mode_active_d = (state_d == S_IDLE) ? 2'b00 : mode_d;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_sample  = out_sample_q;
  assign busy        = busy_q;
  assign mode_active = mode_active_q;
  assign sat_flag    = sat_q;

endmodule
